rt_frame_scheduler: RTL and testbench

Frame-level sequencer for a single RTcore pixel engine. On START it scans every pixel of an H_RES x V_RES frame in raster order, issues one request per pixel over the RTcore ENABLE/OUTPUT_READY handshake, and writes each returned 4-bit pixel into the framebuffer over a valid/ready write port. It sits between the top-level control and the RTcore/framebuffer pair. It supports one-shot or continuous rendering, abort, and an acknowledge-timeout retry.

---
 rtl/rt_frame_scheduler_if.sv | 25 ++
 rtl/rt_frame_scheduler.sv | 150 +++++++++++++++
 tb/tb_rt_frame_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rt_frame_scheduler_if.sv
// Request/result handshake with the RTcore and the framebuffer write port,
// bundled for the frame scheduler.
interface rt_frame_scheduler_if #(
    parameter int ADDR_W = 19
);
    logic              RT_ENABLE;
    logic [9:0]        RT_X;
    logic [8:0]        RT_Y;
    logic              RT_READY;
    logic [3:0]        RT_PIXEL;
    logic              FB_WE;
    logic [ADDR_W-1:0] FB_ADDR;
    logic [3:0]        FB_DATA;
    logic              FB_READY;

    modport master (
        output RT_ENABLE, RT_X, RT_Y, FB_WE, FB_ADDR, FB_DATA,
        input  RT_READY, RT_PIXEL, FB_READY
    );

    modport slave (
        input  RT_ENABLE, RT_X, RT_Y, FB_WE, FB_ADDR, FB_DATA,
        output RT_READY, RT_PIXEL, FB_READY
    );
endinterface

// File: rtl/rt_frame_scheduler.sv
// Frame sequencer: walks an H_RES x V_RES raster, requests each pixel from
// the RTcore and writes the returned value into the framebuffer.
module rt_frame_scheduler #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int ADDR_W      = 19,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic START,
    input  logic CONTINUOUS,
    input  logic ABORT,
    output logic BUSY,
    output logic FRAME_DONE,
    output logic TIMEOUT_ERR,
    rt_frame_scheduler_if.master bus
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WRITE, ADVANCE, DONE, DRAIN
    } state_t;

    state_t            state, state_nxt;
    logic [9:0]        x_q, x_nxt;
    logic [8:0]        y_q, y_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              err_q, err_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [3:0]        data_q, data_nxt;
    logic              last_x, last_y;

    assign last_x = (x_q == 10'(H_RES - 1));
    assign last_y = (y_q == 9'(V_RES - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            x_q    <= '0;
            y_q    <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            x_q    <= x_nxt;
            y_q    <= y_nxt;
            cnt_q  <= cnt_nxt;
            err_q  <= err_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        y_nxt     = y_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        case (state)
            IDLE: begin
                if (START && !ABORT) begin
                    x_nxt     = '0;
                    y_nxt     = '0;
                    err_nxt   = 1'b0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = ABORT ? IDLE : WAIT_ACK;
            end
            WAIT_ACK: begin
                // RT_READY still high here means the request was not taken yet.
                if (ABORT) begin
                    state_nxt = DRAIN;
                end else if (!bus.RT_READY) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (ABORT) begin
                    state_nxt = DRAIN;
                end else if (bus.RT_READY) begin
                    data_nxt  = bus.RT_PIXEL;
                    addr_nxt  = ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (bus.FB_READY) begin
                    state_nxt = ABORT ? IDLE : ADVANCE;
                end
            end
            ADVANCE: begin
                if (ABORT) begin
                    state_nxt = IDLE;
                end else if (last_x && last_y) begin
                    state_nxt = DONE;
                end else begin
                    if (last_x) begin
                        x_nxt = '0;
                        y_nxt = y_q + 1'b1;
                    end else begin
                        x_nxt = x_q + 1'b1;
                    end
                    state_nxt = ISSUE;
                end
            end
            DONE: begin
                if (ABORT) begin
                    state_nxt = IDLE;
                end else if (CONTINUOUS) begin
                    x_nxt     = '0;
                    y_nxt     = '0;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (bus.RT_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An aborted ISSUE cycle must not launch a computation nobody will collect.
    assign bus.RT_ENABLE = (state == ISSUE) && !ABORT;
    assign bus.RT_X      = x_q;
    assign bus.RT_Y      = y_q;
    assign bus.FB_WE     = (state == WRITE);
    assign bus.FB_ADDR   = addr_q;
    assign bus.FB_DATA   = data_q;
    assign BUSY          = (state != IDLE);
    assign FRAME_DONE    = (state == DONE) && !ABORT;
    assign TIMEOUT_ERR   = err_q;
endmodule

// File: tb/tb_rt_frame_scheduler.sv
// Scoreboard bench for rt_frame_scheduler: small 4x2 frame plus a 640-wide
// instance for row wrap, with a 4-cycle RTcore model on each.
`timescale 1ns/1ps
module tb_rt_frame_scheduler;
    localparam int H = 4, V = 2, AW = 19, TMO = 16;
    localparam int HW = 640, VW = 2;

    typedef struct packed { logic [AW-1:0] addr; logic [3:0] data; } wr_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, cont = 1'b0, abort_i = 1'b0, start_w = 1'b0;
    logic busy, frame_done, tmo_err, busy_w, frame_done_w, tmo_err_w;
    int   checks = 0, errors = 0, cyc = 0;
    wr_t  exp_q[$], got_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rt_frame_scheduler_if #(.ADDR_W(AW)) bus ();
    rt_frame_scheduler_if #(.ADDR_W(AW)) busw ();

    rt_frame_scheduler #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .ACK_TIMEOUT(TMO)) dut (
        .CLK(clk), .RESET_N(rst_n), .START(start), .CONTINUOUS(cont), .ABORT(abort_i),
        .BUSY(busy), .FRAME_DONE(frame_done), .TIMEOUT_ERR(tmo_err), .bus(bus));

    rt_frame_scheduler #(.H_RES(HW), .V_RES(VW), .ADDR_W(AW), .ACK_TIMEOUT(TMO)) dut_w (
        .CLK(clk), .RESET_N(rst_n), .START(start_w), .CONTINUOUS(1'b0), .ABORT(1'b0),
        .BUSY(busy_w), .FRAME_DONE(frame_done_w), .TIMEOUT_ERR(tmo_err_w), .bus(busw));

    // RTcore model: result valid in the 4th cycle after the ENABLE cycle, pixel = X ^ Y.
    int m_cnt = 0, m_en_cnt = 0, ignore_idx = -1;
    logic [9:0] m_x;
    logic [8:0] m_y;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.RT_READY <= 1'b1;
            bus.RT_PIXEL <= '0;
            m_cnt        <= 0;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                bus.RT_READY <= 1'b1;
                bus.RT_PIXEL <= 4'(m_x ^ 10'(m_y));
                exp_q.push_back(wr_t'{AW'(int'(m_y) * H + int'(m_x)), 4'(m_x ^ 10'(m_y))});
            end
            m_cnt <= m_cnt - 1;
        end else if (bus.RT_ENABLE) begin
            if (m_en_cnt != ignore_idx) begin
                bus.RT_READY <= 1'b0;
                m_cnt        <= 3;
                m_x          <= bus.RT_X;
                m_y          <= bus.RT_Y;
            end
            m_en_cnt <= m_en_cnt + 1;
        end
    end

    int w_cnt = 0;
    logic [9:0] w_x;
    logic [8:0] w_y;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busw.RT_READY <= 1'b1;
            busw.RT_PIXEL <= '0;
            w_cnt         <= 0;
        end else if (w_cnt != 0) begin
            if (w_cnt == 1) begin
                busw.RT_READY <= 1'b1;
                busw.RT_PIXEL <= 4'(w_x ^ 10'(w_y));
            end
            w_cnt <= w_cnt - 1;
        end else if (busw.RT_ENABLE) begin
            busw.RT_READY <= 1'b0;
            w_cnt         <= 3;
            w_x           <= busw.RT_X;
            w_y           <= busw.RT_Y;
        end
    end

    // Writes that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.FB_WE && bus.FB_READY)
            got_q.push_back(wr_t'{bus.FB_ADDR, bus.FB_DATA});
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || tmo_err !== 1'b0 || busy_w !== 1'b0)
            begin errors++; $display("FAIL reset_status: busy %b done %b err %b busy_w %b, expected 0 0 0 0", busy, frame_done, tmo_err, busy_w); end
        checks++;
        if (bus.RT_ENABLE !== 1'b0 || bus.FB_WE !== 1'b0)
            begin errors++; $display("FAIL reset_strobes: enable %b we %b, expected 0 0", bus.RT_ENABLE, bus.FB_WE); end
        checks++;
        if (bus.FB_ADDR !== '0 || bus.FB_DATA !== 4'd0 || bus.RT_X !== 10'd0 || bus.RT_Y !== 9'd0)
            begin errors++; $display("FAIL reset_data: addr %0d data %0h x %0d y %0d, expected all 0", bus.FB_ADDR, bus.FB_DATA, bus.RT_X, bus.RT_Y); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int en_cyc[$];
        int fd_n = 0, fd_cyc = -1, fall_cyc = -1, bad_gap = 0;
        wr_t g, e;
        exp_q.delete(); got_q.delete();
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.RT_ENABLE) en_cyc.push_back(cyc);
            if (frame_done) begin fd_n++; fd_cyc = cyc; end
            if (fd_cyc >= 0 && !busy) begin fall_cyc = cyc; break; end
        end
        checks++;
        if (fd_n !== 1) begin errors++; $display("FAIL frame_done_count: got %0d, expected 1", fd_n); end
        checks++;
        if (fall_cyc !== fd_cyc + 1) begin errors++; $display("FAIL busy_fall: got cycle %0d, expected %0d", fall_cyc, fd_cyc + 1); end
        checks++;
        if (en_cyc.size() !== 8) begin errors++; $display("FAIL enable_count: got %0d, expected 8", en_cyc.size()); end
        for (int i = 1; i < en_cyc.size(); i++)
            if (en_cyc[i] - en_cyc[i-1] != 7) bad_gap++;
        checks++;
        if (bad_gap !== 0) begin errors++; $display("FAIL pixel_period: %0d gaps differ, expected every gap 7 cycles", bad_gap); end
        checks++;
        if (got_q.size() !== 8) begin errors++; $display("FAIL write_count: got %0d, expected 8", got_q.size()); end
        for (int i = 0; i < 8 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g.addr !== AW'(i))
                begin errors++; $display("FAIL frame_write[%0d]: got addr %0d data %0h, expected addr %0d data %0h", i, g.addr, g.data, e.addr, e.data); end
        end
    endtask

    task automatic test_fb_stall();
        bit seen = 1'b0, seen_we = 1'b0, done = 1'b0;
        int bad_hold = 0, extra_en = 0;
        logic [AW-1:0] a0;
        logic [3:0] d0;
        wr_t g, e;
        exp_q.delete(); got_q.delete();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.RT_ENABLE && bus.RT_X == 10'd2 && bus.RT_Y == 9'd1) begin seen = 1'b1; break; end
        end
        bus.FB_READY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.FB_WE) begin seen_we = 1'b1; break; end
        end
        a0 = bus.FB_ADDR; d0 = bus.FB_DATA;
        checks++;
        if (!seen || !seen_we || a0 !== AW'(1 * H + 2) || d0 !== 4'd3)
            begin errors++; $display("FAIL stall_write: got addr %0d data %0h, expected addr 6 data 3", a0, d0); end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            if (!bus.FB_WE || bus.FB_ADDR !== a0 || bus.FB_DATA !== d0) bad_hold++;
            if (bus.RT_ENABLE) extra_en++;
        end
        @(posedge clk); #1;
        bus.FB_READY = 1'b1;
        checks++;
        if (bad_hold !== 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles, expected 0", bad_hold); end
        checks++;
        if (extra_en !== 0) begin errors++; $display("FAIL stall_enable: got %0d enables, expected 0", extra_en); end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_done) begin done = 1'b1; break; end
        end
        checks++;
        if (!done || got_q.size() !== 8) begin errors++; $display("FAIL stall_frame: done %b writes %0d, expected 1 and 8", done, got_q.size()); end
        for (int i = 0; i < 8 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL stall_sb[%0d]: got addr %0d data %0h, expected addr %0d data %0h", i, g.addr, g.data, e.addr, e.data); end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int first = -1, second = -1;
        bit done = 1'b0;
        wr_t g, e;
        exp_q.delete(); got_q.delete();
        ignore_idx = m_en_cnt;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.RT_ENABLE) begin
                if (first < 0) first = cyc;
                else begin second = cyc; break; end
            end
        end
        checks++;
        if (second - first !== 17) begin errors++; $display("FAIL retry_gap: got %0d cycles, expected 17", second - first); end
        checks++;
        if (tmo_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b, expected 1", tmo_err); end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done) begin done = 1'b1; break; end
        end
        @(negedge clk);
        checks++;
        if (!done || tmo_err !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL timeout_sticky: done %b err %b busy %b, expected 1 1 0", done, tmo_err, busy); end
        checks++;
        if (got_q.size() !== 8) begin errors++; $display("FAIL timeout_writes: got %0d, expected 8", got_q.size()); end
        for (int i = 0; i < 8 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL timeout_sb[%0d]: got addr %0d data %0h, expected addr %0d data %0h", i, g.addr, g.data, e.addr, e.data); end
        end
        pulse_start();
        @(negedge clk);
        checks++;
        if (tmo_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_clear: err %b busy %b, expected 0 1", tmo_err, busy); end
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done) begin done = 1'b1; break; end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL timeout_second_frame: no FRAME_DONE, expected one"); end
        @(negedge clk);
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        int ready_cyc = -1, low_cyc = -1, fd_n = 0;
        wr_t g, e;
        exp_q.delete(); got_q.delete();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.RT_ENABLE && bus.RT_X == 10'd3 && bus.RT_Y == 9'd0) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach: pixel 3 request not seen, expected it"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort_i = 1'b1;
        start   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (frame_done) fd_n++;
            if (ready_cyc < 0 && bus.RT_READY) ready_cyc = cyc;
            if (!busy) begin low_cyc = cyc; break; end
        end
        checks++;
        if (ready_cyc < 0 || low_cyc !== ready_cyc + 1)
            begin errors++; $display("FAIL abort_drain: idle at cycle %0d, expected %0d", low_cyc, ready_cyc + 1); end
        @(posedge clk); #1;
        abort_i = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fd_n !== 0) begin errors++; $display("FAIL abort_idle: busy %b frame_done %0d, expected 0 0", busy, fd_n); end
        checks++;
        if (got_q.size() !== 3 || exp_q.size() !== 4)
            begin errors++; $display("FAIL abort_writes: got %0d writes %0d results, expected 3 4", got_q.size(), exp_q.size()); end
        for (int i = 0; i < 3 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL abort_sb[%0d]: got addr %0d data %0h, expected addr %0d data %0h", i, g.addr, g.data, e.addr, e.data); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_write();
        bit seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.FB_WE) begin seen = 1'b1; break; end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || bus.FB_WE !== 1'b0 || bus.RT_ENABLE !== 1'b0 || busy !== 1'b0 || bus.FB_ADDR !== '0)
            begin errors++; $display("FAIL async_reset: seen %b we %b en %b busy %b addr %0d, expected 1 0 0 0 0", seen, bus.FB_WE, bus.RT_ENABLE, busy, bus.FB_ADDR); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_continuous();
        bit seen = 1'b0;
        wr_t g, e;
        cont = 1'b1;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        checks++;
        if (!seen || bus.RT_ENABLE !== 1'b1 || bus.RT_X !== 10'd0 || bus.RT_Y !== 9'd0 || busy !== 1'b1)
            begin errors++; $display("FAIL cont_restart: done %b en %b x %0d y %0d, expected 1 1 0 0", seen, bus.RT_ENABLE, bus.RT_X, bus.RT_Y); end
        @(posedge clk); #1;
        cont    = 1'b0;
        abort_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        @(posedge clk); #1;
        abort_i = 1'b0;
        checks++;
        if (busy !== 1'b0 || got_q.size() !== 8 || got_q[0].addr !== '0)
            begin errors++; $display("FAIL cont_frame: busy %b writes %0d, expected 0 8 starting at address 0", busy, got_q.size()); end
        for (int i = 0; i < 8 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL cont_sb[%0d]: got addr %0d data %0h, expected addr %0d data %0h", i, g.addr, g.data, e.addr, e.data); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_row_wrap();
        int nwr = 0, last_addr = -1, px = -1, py = -1;
        bit wrap_en = 1'b0, wrap_wr = 1'b0, done = 1'b0;
        @(posedge clk); #1;
        start_w = 1'b1;
        @(posedge clk); #1;
        start_w = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (busw.RT_ENABLE) begin
                if (!wrap_en && busw.RT_Y == 9'd1) begin
                    wrap_en = 1'b1;
                    checks++;
                    if (busw.RT_X !== 10'd0 || px != HW - 1 || py != 0)
                        begin errors++; $display("FAIL wrap_issue: x %0d after (%0d,%0d), expected 0 after (639,0)", busw.RT_X, px, py); end
                end
                px = int'(busw.RT_X);
                py = int'(busw.RT_Y);
            end
            if (busw.FB_WE) begin
                if (last_addr == HW - 1) begin
                    wrap_wr = 1'b1;
                    checks++;
                    if (busw.FB_ADDR !== AW'(HW) || busw.FB_DATA !== 4'd1)
                        begin errors++; $display("FAIL wrap_write: addr %0d data %0h, expected 640 1", busw.FB_ADDR, busw.FB_DATA); end
                end
                last_addr = int'(busw.FB_ADDR);
                nwr++;
            end
            if (frame_done_w) begin done = 1'b1; break; end
        end
        checks++;
        if (!done || !wrap_en || !wrap_wr || tmo_err_w !== 1'b0)
            begin errors++; $display("FAIL wrap_frame: done %b issue %b write %b err %b, expected 1 1 1 0", done, wrap_en, wrap_wr, tmo_err_w); end
        checks++;
        if (last_addr != HW * VW - 1 || nwr != HW * VW)
            begin errors++; $display("FAIL wrap_last: last addr %0d writes %0d, expected %0d %0d", last_addr, nwr, HW * VW - 1, HW * VW); end
    endtask

    initial begin
        bus.FB_READY  = 1'b1;
        busw.FB_READY = 1'b1;
        test_reset();
        test_single_frame();
        test_fb_stall();
        test_timeout();
        test_abort();
        test_reset_mid_write();
        test_continuous();
        test_row_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
